// File: rtl/frame_sequencer_if.sv
// Link-side bundle for frame_sequencer: sample input, control strobes and
// the framed serial output with its status.
interface frame_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             EN;
  logic [7:0]       SAMPLE_IN;
  logic             SAMPLE_VALID;
  logic             CLR_FLAGS;
  logic             DATA_OUT;
  logic             SYNC;
  logic             OVERRUN;
  logic             UNDERRUN;
  logic [CNT_W-1:0] FRAME_CNT;

  // Producer / uC side: drives samples and control, observes the link
  modport master (
    output EN, SAMPLE_IN, SAMPLE_VALID, CLR_FLAGS,
    input  DATA_OUT, SYNC, OVERRUN, UNDERRUN, FRAME_CNT
  );

  // Sequencer side
  modport slave (
    input  EN, SAMPLE_IN, SAMPLE_VALID, CLR_FLAGS,
    output DATA_OUT, SYNC, OVERRUN, UNDERRUN, FRAME_CNT
  );
endinterface

// File: rtl/frame_sequencer.sv
// Radio serial link framer: sync header followed by FRAME_SAMPLES 8-bit
// sample words sent LSB first, one bit per SYS_CLK, fed from a one-deep
// holding register. Optional trailing even-parity bit when the macro
// FRAME_PARITY_EN is defined.
module frame_sequencer #(
  parameter int unsigned FRAME_SAMPLES = 64,
  parameter int unsigned SYNC_LEN      = 16,
  parameter logic [31:0] SYNC_PATTERN  = 32'h0000EB90,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  frame_sequencer_if.slave  bus
);

  // bit_cnt covers header positions up to 31 and payload positions 0..7
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned WORD_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;

`ifdef FRAME_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;
`endif

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               data_q, data_d;
  logic               sync_q, sync_d;
  logic               overrun_q, overrun_d;
  logic               underrun_q, underrun_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
`ifdef FRAME_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               consume_c;
  logic               ovr_set_c;
  logic               und_set_c;
  logic [7:0]         word_c;
  logic [4:0]         sync_idx_c;

  // Header bit index, MSB of the used pattern first
  assign sync_idx_c = 5'(SYNC_LEN - 1) - bit_cnt_q;

  // Next-state, datapath and holding-register logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = 1'b0;
    sync_d      = 1'b0;
    consume_c   = 1'b0;
    ovr_set_c   = 1'b0;
    und_set_c   = 1'b0;
    word_c      = 8'h00;
`ifdef FRAME_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        hold_full_d = 1'b0;
        bit_cnt_d   = '0;
        if (bus.EN) state_d = S_HDR;
      end

      S_HDR: begin
        sync_d = 1'b1;
        data_d = SYNC_PATTERN[sync_idx_c];
        if (bit_cnt_q == BIT_W'(SYNC_LEN - 1)) begin
          state_d    = S_PAY;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
`ifdef FRAME_PARITY_EN
          parity_d   = 1'b0;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      S_PAY: begin
        if (bit_cnt_q == '0) begin
          // Word boundary: take the held sample or substitute zeros
          consume_c = 1'b1;
          if (hold_full_q) word_c = hold_q;
          else             und_set_c = 1'b1;
          data_d  = word_c[0];
          shift_d = {1'b0, word_c[7:1]};
        end else begin
          data_d  = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
`ifdef FRAME_PARITY_EN
        parity_d = parity_q ^ data_d;
`endif
        if (bit_cnt_q == BIT_W'(7)) begin
          bit_cnt_d = '0;
          if (word_cnt_q == WORD_W'(FRAME_SAMPLES - 1)) begin
`ifdef FRAME_PARITY_EN
            state_d = S_PAR;
`else
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = bus.EN ? S_HDR : S_IDLE;
`endif
          end else begin
            word_cnt_d = word_cnt_q + WORD_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

`ifdef FRAME_PARITY_EN
      S_PAR: begin
        data_d      = parity_q;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        state_d     = bus.EN ? S_HDR : S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // One-deep holding register; a same-edge consume frees the slot
    if (state_q != S_IDLE) begin
      if (bus.SAMPLE_VALID) begin
        if (!hold_full_q || consume_c) begin
          hold_d      = bus.SAMPLE_IN;
          hold_full_d = 1'b1;
        end else begin
          ovr_set_c = 1'b1;
        end
      end else if (consume_c) begin
        hold_full_d = 1'b0;
      end
    end

    // Sticky flags, set has priority over clear
    overrun_d  = ovr_set_c | (overrun_q  & ~bus.CLR_FLAGS);
    underrun_d = und_set_c | (underrun_q & ~bus.CLR_FLAGS);
  end

  // State and output registers
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      data_q      <= 1'b0;
      sync_q      <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FRAME_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      data_q      <= data_d;
      sync_q      <= sync_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.DATA_OUT  = data_q;
  assign bus.SYNC      = sync_q;
  assign bus.OVERRUN   = overrun_q;
  assign bus.UNDERRUN  = underrun_q;
  assign bus.FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with FRAME_SAMPLES=2 and a 2-bit
// frame counter so that counter wrap is reached in a few frames.
module tb_frame_sequencer;

  localparam int unsigned FS = 2;
  localparam int unsigned CW = 2;
`ifdef FRAME_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_STEPS = 16 + 8 * FS + PAR_BITS;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] hdr;
  logic [15:0] pay;
  logic        par;
  logic        sync_ok;

  frame_sequencer_if #(.CNT_W(CW)) bus ();

  frame_sequencer #(
    .FRAME_SAMPLES(FS),
    .SYNC_LEN(16),
    .SYNC_PATTERN(32'h0000EB90),
    .CNT_W(CW)
  ) dut (
    .SYS_CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame starting at the edge that drives header bit 0.
  // Strobes/clear/EN-drop are placed by frame step index (-1 = none).
  task automatic run_frame(
    input  int         s0_at, input logic [7:0] s0_w,
    input  int         s1_at, input logic [7:0] s1_w,
    input  int         s2_at, input logic [7:0] s2_w,
    input  int         clr_at,
    input  int         en_drop_at,
    output logic [15:0] h,
    output logic [15:0] p,
    output logic        pb,
    output logic        ok
  );
    h  = '0;
    p  = '0;
    pb = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < FRAME_STEPS; i++) begin
      bus.SAMPLE_VALID = 1'b0;
      bus.CLR_FLAGS    = 1'b0;
      if (i == s0_at) begin bus.SAMPLE_VALID = 1'b1; bus.SAMPLE_IN = s0_w; end
      if (i == s1_at) begin bus.SAMPLE_VALID = 1'b1; bus.SAMPLE_IN = s1_w; end
      if (i == s2_at) begin bus.SAMPLE_VALID = 1'b1; bus.SAMPLE_IN = s2_w; end
      if (i == clr_at) bus.CLR_FLAGS = 1'b1;
      if (i == en_drop_at) bus.EN = 1'b0;
      step();
      if (i < 16) begin
        h[15 - i] = bus.DATA_OUT;
        ok = ok & (bus.SYNC == 1'b1);
      end else begin
        if (i < 32) p[i - 16] = bus.DATA_OUT;
        else        pb = bus.DATA_OUT;
        ok = ok & (bus.SYNC == 1'b0);
      end
    end
    bus.SAMPLE_VALID = 1'b0;
    bus.CLR_FLAGS    = 1'b0;
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.EN           = 1'b0;
    bus.SAMPLE_IN    = 8'h00;
    bus.SAMPLE_VALID = 1'b0;
    bus.CLR_FLAGS    = 1'b0;
    rst              = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_data", 32'(bus.DATA_OUT), 32'd0);
    check("rst_sync", 32'(bus.SYNC), 32'd0);
    check("rst_ovr", 32'(bus.OVERRUN), 32'd0);
    check("rst_und", 32'(bus.UNDERRUN), 32'd0);
    check("rst_fcnt", 32'(bus.FRAME_CNT), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("idle_sync", 32'(bus.SYNC), 32'd0);

    // Start: the IDLE->HDR edge still shows idle outputs
    bus.EN = 1'b1;
    step();
    check("start_sync", 32'(bus.SYNC), 32'd0);
    check("start_data", 32'(bus.DATA_OUT), 32'd0);

    // F1: no samples, zero payload with underrun
    run_frame(-1, 8'h00, -1, 8'h00, -1, 8'h00, -1, -1, hdr, pay, par, sync_ok);
    check("f1_hdr", 32'(hdr), 32'h0000EB90);
    check("f1_sync", 32'(sync_ok), 32'd1);
    check("f1_pay", 32'(pay), 32'h0000);
    check("f1_und", 32'(bus.UNDERRUN), 32'd1);
    check("f1_ovr", 32'(bus.OVERRUN), 32'd0);
    check("f1_fcnt", 32'(bus.FRAME_CNT), 32'd1);

    // F2: A5 then 3C, flags cleared in header
    run_frame(2, 8'hA5, 17, 8'h3C, -1, 8'h00, 0, -1, hdr, pay, par, sync_ok);
    check("f2_hdr", 32'(hdr), 32'h0000EB90);
    check("f2_sync", 32'(sync_ok), 32'd1);
    check("f2_pay", 32'(pay), 32'h3CA5);
    check("f2_und", 32'(bus.UNDERRUN), 32'd0);
    check("f2_fcnt", 32'(bus.FRAME_CNT), 32'd2);
`ifdef FRAME_PARITY_EN
    check("f2_par", 32'(par), 32'd0);
`endif

    // F3: 11 held, two 22 strobes dropped
    run_frame(2, 8'h11, 5, 8'h22, 6, 8'h22, -1, -1, hdr, pay, par, sync_ok);
    check("f3_pay", 32'(pay), 32'h0011);
    check("f3_ovr", 32'(bus.OVERRUN), 32'd1);
    check("f3_und", 32'(bus.UNDERRUN), 32'd1);
    check("f3_fcnt", 32'(bus.FRAME_CNT), 32'd3);

    // F4: load on the consume edge is accepted; clear; counter wraps
    run_frame(2, 8'h5A, 16, 8'hC3, -1, 8'h00, 16, -1, hdr, pay, par, sync_ok);
    check("f4_pay", 32'(pay), 32'hC35A);
    check("f4_ovr", 32'(bus.OVERRUN), 32'd0);
    check("f4_und", 32'(bus.UNDERRUN), 32'd0);
    check("f4_fcnt_wrap", 32'(bus.FRAME_CNT), 32'd0);

    // F5: clear collides with underrun set; EN dropped at payload bit 5
    run_frame(-1, 8'h00, -1, 8'h00, -1, 8'h00, 24, 21, hdr, pay, par, sync_ok);
    check("f5_hdr", 32'(hdr), 32'h0000EB90);
    check("f5_pay", 32'(pay), 32'h0000);
    check("f5_und_setwins", 32'(bus.UNDERRUN), 32'd1);
    check("f5_fcnt", 32'(bus.FRAME_CNT), 32'd1);
    step();
    check("idle_data", 32'(bus.DATA_OUT), 32'd0);
    check("idle_sync2", 32'(bus.SYNC), 32'd0);

    // IDLE: clear works, strobes discarded without overrun
    bus.CLR_FLAGS = 1'b1;
    step();
    bus.CLR_FLAGS = 1'b0;
    check("idle_clr_und", 32'(bus.UNDERRUN), 32'd0);
    bus.SAMPLE_IN    = 8'h99;
    bus.SAMPLE_VALID = 1'b1;
    step();
    step();
    bus.SAMPLE_VALID = 1'b0;
    check("idle_ovr", 32'(bus.OVERRUN), 32'd0);
    check("idle_sync3", 32'(bus.SYNC), 32'd0);
    check("idle_fcnt", 32'(bus.FRAME_CNT), 32'd1);

    // F6: restart; flushed register gives zero payload
    bus.EN = 1'b1;
    step();
    run_frame(-1, 8'h00, -1, 8'h00, -1, 8'h00, -1, -1, hdr, pay, par, sync_ok);
    check("f6_hdr", 32'(hdr), 32'h0000EB90);
    check("f6_pay_flushed", 32'(pay), 32'h0000);
    check("f6_fcnt", 32'(bus.FRAME_CNT), 32'd2);

    // Async reset at header bit 7
    for (int i = 0; i < 8; i++) step();
    check("hb7_data", 32'(bus.DATA_OUT), 32'd1);
    check("hb7_sync", 32'(bus.SYNC), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_data", 32'(bus.DATA_OUT), 32'd0);
    check("arst_sync", 32'(bus.SYNC), 32'd0);
    check("arst_fcnt", 32'(bus.FRAME_CNT), 32'd0);
    check("arst_und", 32'(bus.UNDERRUN), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rel_sync", 32'(bus.SYNC), 32'd0);

    // F7: header restarts from MSB
    run_frame(-1, 8'h00, -1, 8'h00, -1, 8'h00, -1, -1, hdr, pay, par, sync_ok);
    check("f7_hdr", 32'(hdr), 32'h0000EB90);
    check("f7_sync", 32'(sync_ok), 32'd1);
    check("f7_fcnt", 32'(bus.FRAME_CNT), 32'd1);

    // F8/F9: parity vectors
    run_frame(2, 8'h01, 17, 8'h00, -1, 8'h00, -1, -1, hdr, pay, par, sync_ok);
    check("f8_pay", 32'(pay), 32'h0001);
    check("f8_fcnt", 32'(bus.FRAME_CNT), 32'd2);
`ifdef FRAME_PARITY_EN
    check("f8_par", 32'(par), 32'd1);
`endif
    run_frame(2, 8'h03, 17, 8'h00, -1, 8'h00, -1, -1, hdr, pay, par, sync_ok);
    check("f9_hdr", 32'(hdr), 32'h0000EB90);
    check("f9_pay", 32'(pay), 32'h0003);
    check("f9_fcnt", 32'(bus.FRAME_CNT), 32'd3);
`ifdef FRAME_PARITY_EN
    check("f9_par", 32'(par), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
